nn_node_epoch_ctrl: RTL and testbench
=====================================

NN_NODE_EPOCH_CTRL -- requirements
Module: nn_node_epoch_ctrl

Interface
REQ-001 SHALL have parameter M, default 4: number of stochastic nodes sequenced.
REQ-002 SHALL have parameter CNT_W, default 8: width of each per-node pulse counter.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 16: cycles between node clear and the start of evaluation; 0 is legal.
REQ-004 SHALL have parameter EVAL_CYCLES, default 200: length of the evaluation window; must be at least 1.
REQ-005 SHALL have port CLK, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-006 SHALL have port INIT, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port START, input, 1 bit: request to begin one epoch.
REQ-008 SHALL have port ABORT, input, 1 bit: cancels the epoch in progress.
REQ-009 SHALL have port A_OUT, input, M bits: node burst outputs, one bit per node.
REQ-010 SHALL have port NODE_INIT, output, 1 bit: synchronous clear to the node bank.
REQ-011 SHALL have port BUSY, output, 1 bit: high while an epoch is in progress.
REQ-012 SHALL have port DONE, output, 1 bit: one-cycle epoch-complete strobe.
REQ-013 SHALL have port COUNT_OUT, output, M*CNT_W bits: per-node high-cycle counts; node n occupies slice [n*CNT_W +: CNT_W].
REQ-014 SHALL have port MAX_IDX, output, clog2(M) bits (minimum 1): index of the node with the highest count.

Function
REQ-015 SHALL implement states IDLE, CLEAR, SETTLE, EVAL and REPORT.
REQ-016 IDLE: when START=1, SHALL go to CLEAR on the next cycle.
REQ-017 CLEAR: SHALL last exactly 2 cycles with NODE_INIT=1 and all counters zeroed, then go to SETTLE, or to EVAL when SETTLE_CYCLES=0.
REQ-018 SETTLE: SHALL last SETTLE_CYCLES cycles with NODE_INIT=0 and counters held.
REQ-019 EVAL: SHALL last EVAL_CYCLES cycles; in each cycle, counter n increments when A_OUT[n]=1.
REQ-020 Counters SHALL saturate at 2^CNT_W-1; a counter never wraps.
REQ-021 REPORT: SHALL last 1 cycle with DONE=1, then go to IDLE.
REQ-022 COUNT_OUT and MAX_IDX SHALL be valid from the REPORT cycle and held until the next CLEAR.
REQ-023 MAX_IDX SHALL be the lowest index among equal maximum counts; all-zero counts give MAX_IDX=0.
REQ-024 BUSY SHALL be 1 in CLEAR, SETTLE, EVAL and REPORT, and 0 in IDLE.
REQ-025 START while BUSY=1 SHALL be ignored.
REQ-026 ABORT=1 in any non-IDLE state SHALL force IDLE on the next cycle, zero the counters, and produce no DONE.
REQ-027 ABORT SHALL take priority over START and over every state transition in the same cycle.
REQ-028 START and ABORT both 1 in IDLE SHALL leave the block in IDLE.
REQ-029 Latency: START at cycle t gives DONE at t+1+2+SETTLE_CYCLES+EVAL_CYCLES.

Reset
REQ-030 INIT=0 SHALL immediately force state IDLE, all counters 0, NODE_INIT=0, BUSY=0, DONE=0, COUNT_OUT=0 and MAX_IDX=0.
REQ-031 Reset asserted mid-epoch SHALL discard the epoch; after release the block waits in IDLE for a new START.
REQ-032 The first START SHALL be accepted in the first cycle after INIT deasserts.

Configuration
REQ-033 With macro NN_NODE_EPOCH_CTRL_AUTORESTART_EN defined, REPORT SHALL go directly to CLEAR, so epochs repeat until ABORT.
REQ-034 With the macro defined, BUSY SHALL stay 1 across repeated epochs and DONE SHALL pulse once per epoch.
REQ-035 Without the macro, REPORT SHALL always go to IDLE, and a new START is required for each epoch.

Structure
REQ-036 Shared package nn_epoch_pkg SHALL hold the state encoding, the CLEAR_CYCLES=2 constant, and the helper function for the index width.
REQ-037 One sub-module nn_pulse_counter (width CNT_W; clear, enable and saturation) SHALL be instantiated M times.
REQ-038 The MAX_IDX comparison tree SHALL be inline in the top module.

Verification
REQ-039 Scenario: M=4, SETTLE_CYCLES=3, EVAL_CYCLES=10, A_OUT=4'b0101 held, START at cycle 5 -> DONE at cycle 21; counts {0,10,0,10}; MAX_IDX=0.
REQ-040 Scenario: CNT_W=4, EVAL_CYCLES=20, A_OUT[2]=1 held -> count[2]=15 (saturated); MAX_IDX=2.
REQ-041 Scenario: ABORT in EVAL cycle 4 -> IDLE next cycle; counters 0; DONE never asserts; BUSY=0.
REQ-042 Scenario: START pulsed during SETTLE -> ignored; exactly one DONE.
REQ-043 Scenario: INIT=0 mid-EVAL -> all outputs 0 immediately, without waiting for a clock edge; START after release -> full epoch with correct counts.
REQ-044 Scenario: NN_NODE_EPOCH_CTRL_AUTORESTART_EN defined, SETTLE_CYCLES=0, EVAL_CYCLES=5 -> DONE every 8 cycles; NODE_INIT high for 2 cycles after each DONE.

Source files
------------

// File: rtl/nn_epoch_pkg.sv
// -----------------------------------------------------------------------------
// nn_epoch_pkg
// Declarations shared by the epoch controller and its sub-module:
//   state_e      - controller state encoding
//   CLEAR_CYCLES - number of cycles the node bank is held in clear
//   idx_width()  - width of an index into M nodes, never less than 1 bit
// -----------------------------------------------------------------------------
package nn_epoch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_EVAL   = 3'd3,
    ST_REPORT = 3'd4
  } state_e;

  localparam int CLEAR_CYCLES = 2;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nn_pulse_counter.sv
// -----------------------------------------------------------------------------
// nn_pulse_counter
// Saturating up-counter that tallies the cycles a node output is high.
// Ports:
//   clk_i  - clock (rising edge)
//   rst_ni - asynchronous active-low reset
//   clr_i  - synchronous clear, wins over en_i
//   en_i   - count this cycle
//   cnt_o  - current count, sticks at all-ones instead of wrapping
// -----------------------------------------------------------------------------
module nn_pulse_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/nn_node_epoch_ctrl.sv
// -----------------------------------------------------------------------------
// nn_node_epoch_ctrl
// Sequences one evaluation epoch of a bank of M stochastic nodes:
// clear the bank, let it settle, count high cycles of each node output over an
// evaluation window, then report the counts and the index of the winner.
// Ports:
//   CLK       - clock (rising edge)
//   INIT      - asynchronous active-low reset
//   START     - begin an epoch (ignored while busy)
//   ABORT     - cancel the running epoch, clears counters, no DONE
//   A_OUT     - node burst outputs, one bit per node
//   NODE_INIT - clear to the node bank (high during CLEAR)
//   BUSY      - epoch in progress
//   DONE      - one-cycle epoch-complete strobe
//   COUNT_OUT - per-node counts, node n at [n*CNT_W +: CNT_W]
//   MAX_IDX   - lowest index holding the maximum count
// Build option: define NN_NODE_EPOCH_CTRL_AUTORESTART_EN to make REPORT go
// straight back to CLEAR so epochs repeat until ABORT.
// -----------------------------------------------------------------------------
module nn_node_epoch_ctrl
  import nn_epoch_pkg::*;
#(
  parameter int M             = 4,
  parameter int CNT_W         = 8,
  parameter int SETTLE_CYCLES = 16,
  parameter int EVAL_CYCLES   = 200
) (
  input  logic                    CLK,
  input  logic                    INIT,
  input  logic                    START,
  input  logic                    ABORT,
  input  logic [M-1:0]            A_OUT,
  output logic                    NODE_INIT,
  output logic                    BUSY,
  output logic                    DONE,
  output logic [M*CNT_W-1:0]      COUNT_OUT,
  output logic [idx_width(M)-1:0] MAX_IDX
);

  localparam int IW    = idx_width(M);
  localparam int TMAX0 = (SETTLE_CYCLES > EVAL_CYCLES) ? SETTLE_CYCLES : EVAL_CYCLES;
  localparam int TMAX  = (TMAX0 > CLEAR_CYCLES) ? TMAX0 : CLEAR_CYCLES;
  localparam int TW    = $clog2(TMAX + 1);

  // Terminal timer values; the timer restarts at 0 on every state change.
  localparam logic [TW-1:0] CLEAR_LAST  = TW'(CLEAR_CYCLES - 1);
  localparam logic [TW-1:0] SETTLE_LAST = TW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [TW-1:0] EVAL_LAST   = TW'(EVAL_CYCLES - 1);

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;

  logic             cnt_clr;
  logic             cnt_en;
  logic [CNT_W-1:0] cnt [M];

  always_ff @(posedge CLK or negedge INIT) begin
    if (!INIT) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q + 1'b1;
    case (state_q)
      ST_IDLE:   if (START) state_d = ST_CLEAR;
      ST_CLEAR:  if (timer_q == CLEAR_LAST)
                   state_d = (SETTLE_CYCLES == 0) ? ST_EVAL : ST_SETTLE;
      ST_SETTLE: if (timer_q == SETTLE_LAST) state_d = ST_EVAL;
      ST_EVAL:   if (timer_q == EVAL_LAST) state_d = ST_REPORT;
`ifdef NN_NODE_EPOCH_CTRL_AUTORESTART_EN
      ST_REPORT: state_d = ST_CLEAR;
`else
      ST_REPORT: state_d = ST_IDLE;
`endif
      default:   state_d = ST_IDLE;
    endcase
    // ABORT overrides every transition, including START in IDLE.
    if (ABORT) state_d = ST_IDLE;
    if ((state_d != state_q) || (state_q == ST_IDLE)) timer_d = '0;
  end

  assign NODE_INIT = (state_q == ST_CLEAR);
  assign BUSY      = (state_q != ST_IDLE);
  // Gated so an abort landing in REPORT produces no completion strobe.
  assign DONE      = (state_q == ST_REPORT) && !ABORT;

  assign cnt_clr = (state_q == ST_CLEAR) || (ABORT && BUSY);
  assign cnt_en  = (state_q == ST_EVAL);

  generate
    for (genvar gi = 0; gi < M; gi++) begin : g_node
      nn_pulse_counter #(
        .CNT_W (CNT_W)
      ) u_cnt (
        .clk_i  (CLK),
        .rst_ni (INIT),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en && A_OUT[gi]),
        .cnt_o  (cnt[gi])
      );
      assign COUNT_OUT[gi*CNT_W +: CNT_W] = cnt[gi];
    end
  endgenerate

  // Strict greater-than keeps the lowest index on ties; all-zero gives 0.
  logic [CNT_W-1:0] best_cnt;
  logic [IW-1:0]    best_idx;

  always_comb begin
    best_cnt = cnt[0];
    best_idx = '0;
    for (int n = 1; n < M; n++) begin
      if (cnt[n] > best_cnt) begin
        best_cnt = cnt[n];
        best_idx = IW'(n);
      end
    end
  end

  assign MAX_IDX = best_idx;

endmodule

// File: tb/tb_nn_node_epoch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_nn_node_epoch_ctrl
// Directed bench over three controller instances:
//   d=0 : M=4 CNT_W=8 SETTLE=3 EVAL=10
//   d=1 : M=4 CNT_W=4 SETTLE=3 EVAL=20 (saturation)
//   d=2 : M=4 CNT_W=8 SETTLE=0 EVAL=5  (zero settle / auto-restart)
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_nn_node_epoch_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       init_n;
  logic       start  [3];
  logic       abort  [3];
  logic [3:0] aout   [3];
  logic       ni_s   [3];
  logic       busy_s [3];
  logic       done_s [3];
  logic [1:0] mx_s   [3];
  logic [31:0] cnt_a, cnt_c;
  logic [15:0] cnt_b;
  logic [31:0] cnt_s [3];

  assign cnt_s[0] = cnt_a;
  assign cnt_s[1] = {16'h0000, cnt_b};
  assign cnt_s[2] = cnt_c;

  nn_node_epoch_ctrl #(.M(4), .CNT_W(8), .SETTLE_CYCLES(3), .EVAL_CYCLES(10)) u_a (
    .CLK(clk), .INIT(init_n), .START(start[0]), .ABORT(abort[0]), .A_OUT(aout[0]),
    .NODE_INIT(ni_s[0]), .BUSY(busy_s[0]), .DONE(done_s[0]), .COUNT_OUT(cnt_a), .MAX_IDX(mx_s[0]));

  nn_node_epoch_ctrl #(.M(4), .CNT_W(4), .SETTLE_CYCLES(3), .EVAL_CYCLES(20)) u_b (
    .CLK(clk), .INIT(init_n), .START(start[1]), .ABORT(abort[1]), .A_OUT(aout[1]),
    .NODE_INIT(ni_s[1]), .BUSY(busy_s[1]), .DONE(done_s[1]), .COUNT_OUT(cnt_b), .MAX_IDX(mx_s[1]));

  nn_node_epoch_ctrl #(.M(4), .CNT_W(8), .SETTLE_CYCLES(0), .EVAL_CYCLES(5)) u_c (
    .CLK(clk), .INIT(init_n), .START(start[2]), .ABORT(abort[2]), .A_OUT(aout[2]),
    .NODE_INIT(ni_s[2]), .BUSY(busy_s[2]), .DONE(done_s[2]), .COUNT_OUT(cnt_c), .MAX_IDX(mx_s[2]));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // n = edges from the START-sampling edge until DONE is seen;
  // nic = cycles NODE_INIT was high in between.
  task automatic run_epoch(input int d, input int limit, output int n, output int nic);
    start[d] = 1'b1;
    tick();
    start[d] = 1'b0;
    n   = 0;
    nic = 0;
    while (!done_s[d] && n < limit) begin
      if (ni_s[d]) nic++;
      tick();
      n++;
    end
  endtask

  task automatic finish_epoch(input int d);
`ifdef NN_NODE_EPOCH_CTRL_AUTORESTART_EN
    abort[d] = 1'b1;
    tick();
    abort[d] = 1'b0;
    chk("stop_busy", {31'd0, busy_s[d]}, 32'd0);
`else
    tick();
    chk("post_report_busy", {31'd0, busy_s[d]}, 32'd0);
    chk("post_report_done", {31'd0, done_s[d]}, 32'd0);
`endif
  endtask

  initial begin
    int n, nic, dn, first, k;
    init_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start[i] = 1'b0;
      abort[i] = 1'b0;
      aout[i]  = 4'h0;
    end
    repeat (3) tick();

    // Reset state
    chk("rst_busy", {31'd0, busy_s[0]}, 32'd0);
    chk("rst_ni",   {31'd0, ni_s[0]},   32'd0);
    chk("rst_done", {31'd0, done_s[0]}, 32'd0);
    chk("rst_cnt",  cnt_s[0], 32'd0);
    chk("rst_mx",   {30'd0, mx_s[0]}, 32'd0);

    // Basic epoch; START raised in the same step INIT releases.
    aout[0] = 4'b0101;
    init_n  = 1'b1;
    run_epoch(0, 40, n, nic);
    chk("s1_latency", n, 32'd15);
    chk("s1_nodeinit", nic, 32'd2);
    chk("s1_busy", {31'd0, busy_s[0]}, 32'd1);
    chk("s1_cnt", cnt_s[0], 32'h000A_000A);
    chk("s1_mx", {30'd0, mx_s[0]}, 32'd0);
    finish_epoch(0);

    // Different pattern, tie between nodes 1 and 3
    aout[0] = 4'b1010;
    run_epoch(0, 40, n, nic);
    chk("s1b_latency", n, 32'd15);
    chk("s1b_cnt", cnt_s[0], 32'h0A00_0A00);
    chk("s1b_mx", {30'd0, mx_s[0]}, 32'd1);
    finish_epoch(0);

    // Saturation at 15 with CNT_W=4
    aout[1] = 4'b0100;
    run_epoch(1, 60, n, nic);
    chk("s2_latency", n, 32'd25);
    chk("s2_cnt", cnt_s[1], 32'h0000_0F00);
    chk("s2_mx", {30'd0, mx_s[1]}, 32'd2);
    finish_epoch(1);

    // SETTLE_CYCLES=0
    aout[2] = 4'b1000;
    run_epoch(2, 30, n, nic);
    chk("s3_latency", n, 32'd7);
    chk("s3_nodeinit", nic, 32'd2);
    chk("s3_cnt", cnt_s[2], 32'h0500_0000);
    chk("s3_mx", {30'd0, mx_s[2]}, 32'd3);
`ifdef NN_NODE_EPOCH_CTRL_AUTORESTART_EN
    k = 0;
    nic = 0;
    do begin
      tick();
      k++;
      if (ni_s[2]) nic++;
      if (k <= 2) chk("ar_nodeinit_hi", {31'd0, ni_s[2]}, 32'd1);
      chk("ar_busy", {31'd0, busy_s[2]}, 32'd1);
    end while (!done_s[2] && k < 20);
    chk("ar_period", k, 32'd8);
    chk("ar_nodeinit_cycles", nic, 32'd2);
    chk("ar_cnt", cnt_s[2], 32'h0500_0000);
`endif
    finish_epoch(2);

    // ABORT in EVAL
    aout[0] = 4'hF;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    repeat (8) tick();
    chk("s4_live_cnt", cnt_s[0], 32'h0303_0303);
    abort[0] = 1'b1;
    tick();
    abort[0] = 1'b0;
    chk("s4_busy", {31'd0, busy_s[0]}, 32'd0);
    chk("s4_cnt", cnt_s[0], 32'd0);
    chk("s4_done", {31'd0, done_s[0]}, 32'd0);
    chk("s4_ni", {31'd0, ni_s[0]}, 32'd0);
    chk("s4_mx", {30'd0, mx_s[0]}, 32'd0);
    dn = 0;
    repeat (30) begin
      tick();
      if (done_s[0]) dn++;
    end
    chk("s4_no_done", dn, 32'd0);

    // START during SETTLE is ignored
    aout[0] = 4'b0001;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    repeat (3) tick();
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    dn = 0;
    first = -1;
    for (int i = 5; i <= 25; i++) begin
      if (done_s[0]) begin
        dn++;
        if (first < 0) first = i - 1;
      end
      tick();
    end
    chk("s5_done_count", dn, 32'd1);
    chk("s5_done_at", first, 32'd15);
    finish_epoch(0);

    // INIT mid-EVAL
    aout[0] = 4'hF;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    repeat (8) tick();
    init_n = 1'b0;
    #2;
    chk("s6_busy", {31'd0, busy_s[0]}, 32'd0);
    chk("s6_ni", {31'd0, ni_s[0]}, 32'd0);
    chk("s6_done", {31'd0, done_s[0]}, 32'd0);
    chk("s6_cnt", cnt_s[0], 32'd0);
    chk("s6_mx", {30'd0, mx_s[0]}, 32'd0);
    repeat (2) tick();
    init_n = 1'b1;
    repeat (3) tick();
    chk("s6_idle_after_release", {31'd0, busy_s[0]}, 32'd0);
    aout[0] = 4'b0110;
    run_epoch(0, 40, n, nic);
    chk("s6_latency", n, 32'd15);
    chk("s6_cnt_after", cnt_s[0], 32'h000A_0A00);
    chk("s6_mx_after", {30'd0, mx_s[0]}, 32'd1);
    finish_epoch(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
